// File: rtl/jtpang_objdma_pkg.sv
// Shared definitions for the object-RAM DMA: state encoding and default transfer length.
package jtpang_objdma_pkg;

    localparam int unsigned DMA_LEN_DEF = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_LAST,
        ST_REL
    } dma_state_t;

endpackage

// File: rtl/jtpang_objdma_if.sv
// CPU bus handshake, VRAM read port and object-buffer write port seen by the DMA engine.
interface jtpang_objdma_if;

    logic       busrq_n;
    logic       busak_n;
    logic [8:0] dma_addr;
    logic [7:0] vram_dout;
    logic [8:0] obj_addr;
    logic [7:0] obj_din;
    logic       obj_we;

    modport master (
        output busrq_n, dma_addr, obj_addr, obj_din, obj_we,
        input  busak_n, vram_dout
    );

    modport slave (
        input  busrq_n, dma_addr, obj_addr, obj_din, obj_we,
        output busak_n, vram_dout
    );

endinterface

// File: rtl/jtpang_objdma.sv
// Object DMA: grabs the CPU bus and copies DMA_LEN bytes of VRAM object area into the object buffer.
module jtpang_objdma
    import jtpang_objdma_pkg::*;
#(
    parameter int unsigned DMA_LEN = DMA_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             dma_go,
    output logic             busy,
    jtpang_objdma_if.master  bus
);

    localparam logic [8:0] LAST_ADDR = 9'(DMA_LEN - 1);

    dma_state_t state, state_nx;
    logic [8:0] addr, addr_nx, oaddr_nx;
    logic       we_nx;
    logic       step;

    // A step needs both the clock enable and a live bus grant
    assign step = cen & ~bus.busak_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            bus.obj_addr <= '0;
            bus.obj_we   <= 1'b0;
        end else begin
            state        <= state_nx;
            addr         <= addr_nx;
            bus.obj_addr <= oaddr_nx;
            bus.obj_we   <= we_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        oaddr_nx = bus.obj_addr;
        we_nx    = 1'b0;
        case (state)
            ST_IDLE: if (dma_go) state_nx = ST_REQ;
            ST_REQ: begin
                if (!bus.busak_n) begin
                    state_nx = ST_XFER;
                    addr_nx  = '0;
                end
            end
            ST_XFER: begin
                if (step) begin
                    addr_nx  = addr + 9'd1;
                    oaddr_nx = addr;
                    we_nx    = 1'b1;
                    if (addr == LAST_ADDR - 9'd1) state_nx = ST_LAST;
                end
            end
            ST_LAST: begin
                if (step) begin
                    oaddr_nx = addr;
                    we_nx    = 1'b1;
                    addr_nx  = '0;
                    state_nx = ST_REL;
                end
            end
            ST_REL: if (bus.busak_n) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy         = (state != ST_IDLE);
    assign bus.busrq_n  = ~((state == ST_REQ) || (state == ST_XFER) || (state == ST_LAST));
    assign bus.dma_addr = addr;
    // VRAM data for the byte being written arrives in the same clk as the obj_we pulse,
    // so it is passed straight through rather than registered again
    assign bus.obj_din  = bus.obj_we ? bus.vram_dout : '0;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: full 512-byte copy, bus loss, reset abort, slow cen and no-ack cases.
module tb_jtpang_objdma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go0 = 1'b0;
    logic go8 = 1'b0;
    logic hold0 = 1'b0;
    logic busy0, busy8, cen8;
    logic [1:0] rq0_d = 2'b11;
    logic [1:0] rq8_d = 2'b11;
    logic ak0_edge = 1'b1;
    int cyc = 0;
    int ccnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n0 = 0, e0 = 0, n8 = 0, e8 = 0, last8 = 0;

    always #5 clk = ~clk;

    jtpang_objdma_if b0();
    jtpang_objdma_if b8();

    jtpang_objdma #(.DMA_LEN(512)) dut0 (
        .clk(clk), .rst(rst), .cen(1'b1), .dma_go(go0), .busy(busy0), .bus(b0)
    );

    jtpang_objdma #(.DMA_LEN(8)) dut8 (
        .clk(clk), .rst(rst), .cen(cen8), .dma_go(go8), .busy(busy8), .bus(b8)
    );

    function automatic logic [7:0] vram_byte(input logic [8:0] a);
        logic [12:0] v;
        v = {1'b1, a[8:2], 3'b000, a[1:0]};
        return v[7:0] ^ v[12:5] ^ 8'h5a;
    endfunction

    // CPU grants the bus two clk after the request falls, releases two clk after it rises
    always @(posedge clk) begin
        cyc++;
        rq0_d <= {rq0_d[0], b0.busrq_n};
        rq8_d <= {rq8_d[0], b8.busrq_n};
        ak0_edge <= b0.busak_n;
        b0.vram_dout <= vram_byte(b0.dma_addr);
        b8.vram_dout <= vram_byte(b8.dma_addr);
    end
    assign b0.busak_n = hold0 | rq0_d[1];
    assign b8.busak_n = rq8_d[1];

    always @(negedge clk) ccnt <= (ccnt == 2) ? 0 : ccnt + 1;
    assign cen8 = (ccnt == 2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && b0.obj_we) begin
            check("wr0_addr", 32'(b0.obj_addr), 32'(e0));
            check("wr0_data", 32'(b0.obj_din), 32'(vram_byte(9'(e0))));
            check("wr0_ack", 32'(ak0_edge), 32'd0);
            if (e0 == 511) check("wr0_rel", 32'(b0.busrq_n), 32'd1);
            e0++;
            n0++;
        end
        if (!rst && b8.obj_we) begin
            check("wr8_addr", 32'(b8.obj_addr), 32'(e8));
            check("wr8_data", 32'(b8.obj_din), 32'(vram_byte(9'(e8))));
            if (n8 > 0) check("wr8_spacing", 32'(cyc - last8), 32'd3);
            last8 = cyc;
            e8++;
            n8++;
        end
    end

    task automatic clr_mon();
        n0 = 0; e0 = 0; n8 = 0; e8 = 0;
    endtask

    task automatic pulse0();
        @(negedge clk); go0 = 1'b1;
        @(negedge clk); go0 = 1'b0; #1;
    endtask

    task automatic pulse8();
        @(negedge clk); go8 = 1'b1;
        @(negedge clk); go8 = 1'b0; #1;
    endtask

    task automatic wait_n0(input int n, input int budget);
        int k = 0;
        while (n0 < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_n0", 32'(n0 >= n), 32'd1);
    endtask

    task automatic wait_idle0(input int budget);
        int k = 0;
        while (busy0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_idle0", 32'(busy0), 32'd0);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        n_bad++;
        summary();
        $fatal(1);
    end

    initial begin
        int viol, k, n3;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busrq", 32'(b0.busrq_n), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_dma_addr", 32'(b0.dma_addr), 32'd0);
        check("rst_obj_addr", 32'(b0.obj_addr), 32'd0);
        check("rst_obj_din", 32'(b0.obj_din), 32'd0);
        check("rst_obj_we", 32'(b0.obj_we), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // full transfer, cen always on
        clr_mon();
        pulse0();
        check("req_busrq", 32'(b0.busrq_n), 32'd0);
        check("req_busy", 32'(busy0), 32'd1);
        check("req_dma_addr", 32'(b0.dma_addr), 32'd0);
        wait_idle0(2000);
        check("full_count", 32'(n0), 32'd512);
        check("full_busrq", 32'(b0.busrq_n), 32'd1);
        check("full_dma_addr", 32'(b0.dma_addr), 32'd0);

        // bus lost for 10 clk after write 100
        clr_mon();
        pulse0();
        wait_n0(101, 1000);
        hold0 = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("gap_count", 32'(n0), 32'd101);
        check("gap_busrq", 32'(b0.busrq_n), 32'd0);
        check("gap_dma_addr", 32'(b0.dma_addr), 32'd101);
        hold0 = 1'b0;
        wait_idle0(2000);
        check("gap_total", 32'(n0), 32'd512);

        // reset abort after write 200
        clr_mon();
        pulse0();
        wait_n0(201, 1000);
        rst = 1'b1;
        #1;
        check("abort_busrq", 32'(b0.busrq_n), 32'd1);
        check("abort_obj_we", 32'(b0.obj_we), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_dma_addr", 32'(b0.dma_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clr_mon();
        pulse0();
        wait_idle0(2000);
        check("restart_total", 32'(n0), 32'd512);

        // DMA_LEN=8 with cen every third clk and a stray second go
        clr_mon();
        pulse8();
        check("slow_busy", 32'(busy8), 32'd1);
        viol = 0;
        k = 0;
        while (n8 < 3 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        n3 = n8;
        check("slow_wait3", 32'(n3), 32'd3);
        pulse8();
        k = 0;
        while (busy8 && k < 400) begin
            if ((!b8.busrq_n) && !busy8) viol++;
            @(negedge clk); #1;
            if (!b8.busak_n && !busy8) viol++;
            k++;
        end
        check("slow_idle", 32'(busy8), 32'd0);
        check("slow_busy_held", 32'(viol), 32'd0);
        check("slow_count", 32'(n8), 32'd8);
        repeat (20) @(negedge clk);
        #1;
        check("slow_no_extra", 32'(n8), 32'd8);
        check("slow_busy_after", 32'(busy8), 32'd0);

        // no acknowledge ever
        clr_mon();
        hold0 = 1'b1;
        pulse0();
        repeat (50) @(negedge clk);
        #1;
        check("noack_busrq", 32'(b0.busrq_n), 32'd0);
        check("noack_busy", 32'(busy0), 32'd1);
        check("noack_dma_addr", 32'(b0.dma_addr), 32'd0);
        check("noack_writes", 32'(n0), 32'd0);

        summary();
        $finish;
    end

endmodule

// File: doc/jtpang_objdma.md
JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

Interface
REQ-001 SHALL have parameter DMA_LEN, default 512, bytes copied per transfer (power of two, 4..512).
REQ-002 SHALL have ports: clk  input  1  system clock; rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: cen  input  1  transfer clock enable; one DMA step per enabled clk edge.
REQ-004 SHALL have ports: dma_go  input  1  single-cycle start strobe from CPU port decoder.
REQ-005 SHALL have ports: busrq_n  output  1  CPU bus request, active low; busak_n  input  1  CPU bus acknowledge, active low.
REQ-006 SHALL have ports: dma_addr  output  9  VRAM object-area byte index driven to the tile/object VRAM mux.
REQ-007 SHALL have ports: vram_dout  input  8  VRAM read data, valid one clk after dma_addr changes.
REQ-008 SHALL have ports: obj_addr  output  9  object-buffer write address; obj_din  output  8  write data; obj_we  output  1  write strobe.
REQ-009 SHALL have ports: busy  output  1  high from accepted dma_go until bus released.

Function
REQ-010 SHALL implement states IDLE, REQ, XFER, LAST, REL.
REQ-011 IDLE: dma_go=1 -> REQ, busrq_n<=0, busy<=1; dma_go while not IDLE SHALL be ignored (no queuing).
REQ-012 REQ: hold busrq_n=0 until busak_n=0 sampled, then -> XFER with dma_addr=0; no step before acknowledge.
REQ-013 XFER: on each cen, dma_addr increments by 1; obj_addr SHALL equal previous dma_addr and obj_din SHALL equal vram_dout (one-clk read latency absorbed).
REQ-014 obj_we SHALL pulse for exactly one clk per cen step, first at step for dma_addr=1 (writing index 0), never while busak_n=1.
REQ-015 When dma_addr reaches DMA_LEN-1 and cen, SHALL -> LAST; dma_addr holds DMA_LEN-1, no wrap to 0.
REQ-016 LAST: on next cen, write final byte (obj_addr=DMA_LEN-1), release busrq_n<=1, -> REL; exactly DMA_LEN writes per transfer.
REQ-017 REL: wait for busak_n=1, then -> IDLE, busy<=0; dma_go on the same clk as return to IDLE is ignored.
REQ-018 If busak_n returns to 1 during XFER/LAST (bus lost), SHALL freeze dma_addr, suppress obj_we, keep busrq_n=0, resume on re-acknowledge without skipping or repeating an address.
REQ-019 cen=0 SHALL freeze all state, addresses and suppress obj_we; busak_n sampling in REQ/REL is not cen-gated.
REQ-020 dma_addr SHALL be 0 whenever not in XFER/LAST, so the VRAM mux sees a stable value.

Reset
REQ-021 rst=1 SHALL force, asynchronously: state IDLE, busrq_n=1, busy=0, dma_addr=0, obj_addr=0, obj_din=0, obj_we=0.
REQ-022 rst mid-transfer SHALL abort immediately and release the bus; no partial write completes after rst rises.
REQ-023 After rst falls, first dma_go SHALL start a full transfer from address 0.

Structure
REQ-024 State encoding and default DMA_LEN SHALL live in the shared jtpang package; module uses the localparams from it.
REQ-025 Single flat module, no sub-module; the address counter is inline.
REQ-026 Object buffer RAM is external (instantiated by the object renderer); this block drives only its write port.

Verification
REQ-027 cen=1 always, dma_go pulse, busak_n=0 two clk after busrq_n falls -> exactly 512 obj_we pulses, obj_addr 0..511 in order, obj_din equals VRAM model byte at {1,addr[8:2],000,addr[1:0]}, busrq_n=1 after write 511.
REQ-028 cen every 3rd clk, DMA_LEN=8 -> 8 writes spaced 3 clk, busy high from go to busak_n=1, ignored second dma_go mid-transfer produces no extra writes.
REQ-029 busak_n forced 1 for 10 clk after write 100 -> no obj_we in gap, next write is obj_addr 101, total still 512.
REQ-030 rst pulsed after write 200 -> busrq_n=1 and obj_we=0 same clk; following dma_go restarts at obj_addr 0.
REQ-031 busak_n held 1 forever after dma_go -> block stays in REQ, busrq_n=0, zero writes, dma_addr=0.
